// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types for the round-robin register arbiter: FSM state encoding and
// the index-width helper used to size pointers and owner fields.
package rr_reg_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Width of an index into n items; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_reg_arbiter_pick.sv
// rr_pick: combinational rotating priority encoder. Searches req starting at
// ptr and wrapping modulo N_REQ; reports whether any request exists and the winner.
module rr_pick
   import rr_reg_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PTR_W = idx_width(N_REQ)
)(
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic             found,
   output logic [PTR_W-1:0] winner
);

   // First requester at or after ptr, in wrapped order.
   always_comb begin
      found  = 1'b0;
      winner = {PTR_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         int  cand;
         logic hit;
         cand   = (int'(ptr) + i) % N_REQ;
         hit    = !found && req[cand];
         winner = hit ? PTR_W'(cand) : winner;
         found  = found | hit;
      end
   end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter loading one requester's data per cycle into a shared register.
// Optional owner lock with bounded hold is enabled by defining ARB_LOCK_EN.
module rr_reg_arbiter
   import rr_reg_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ*WIDTH-1:0]       wdata,
`ifdef ARB_LOCK_EN
   input  logic [N_REQ-1:0]             lock,
`endif
   output logic [N_REQ-1:0]             gnt,
   output logic                         wr_stb,
   output logic [idx_width(N_REQ)-1:0]  owner,
   output logic [WIDTH-1:0]             q,
   output logic                         q_valid
);

   localparam int PTR_W = idx_width(N_REQ);

   if (N_REQ < 2 || MAX_HOLD < 1) begin : g_param_check
      $error("rr_reg_arbiter: N_REQ must be >= 2 and MAX_HOLD >= 1");
   end

   arb_state_e        state_r, state_nx_s;
   logic [PTR_W-1:0]  ptr_r, ptr_nx_s;
   logic [N_REQ-1:0]  gnt_r, gnt_nx_s;
   logic              wr_stb_r, wr_stb_nx_s;
   logic [PTR_W-1:0]  owner_r, owner_nx_s;
   logic [WIDTH-1:0]  q_r, q_nx_s;
   logic              q_valid_r, q_valid_nx_s;
   logic              pick_found_s;
   logic [PTR_W-1:0]  pick_winner_s;
   logic [PTR_W-1:0]  win_s;
   logic              keep_s;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_r),
      .found  (pick_found_s),
      .winner (pick_winner_s)
   );

`ifdef ARB_LOCK_EN
   localparam int HOLD_W = idx_width(MAX_HOLD);
   logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nx_s;

   // A locked owner keeps the grant only while it still requests and has hold budget left.
   assign keep_s = (state_r == ST_BUSY) && req[owner_r] && lock[owner_r]
                   && (hold_cnt_r < HOLD_W'(MAX_HOLD - 1));
`else
   assign keep_s = 1'b0;
`endif

   // Next-state and next-output logic; all outputs are registered below.
   always_comb begin
      state_nx_s   = state_r;
      ptr_nx_s     = ptr_r;
      gnt_nx_s     = {N_REQ{1'b0}};
      wr_stb_nx_s  = 1'b0;
      owner_nx_s   = owner_r;
      q_nx_s       = q_r;
      q_valid_nx_s = q_valid_r;
      win_s        = keep_s ? owner_r : pick_winner_s;
`ifdef ARB_LOCK_EN
      hold_cnt_nx_s = {HOLD_W{1'b0}};
`endif
      case (state_r)
         ST_IDLE, ST_BUSY: begin
            if (pick_found_s) begin
               state_nx_s      = ST_BUSY;
               gnt_nx_s[win_s] = 1'b1;
               wr_stb_nx_s     = 1'b1;
               owner_nx_s      = win_s;
               q_nx_s          = wdata[int'(win_s)*WIDTH +: WIDTH];
               q_valid_nx_s    = 1'b1;
               ptr_nx_s        = keep_s ? ptr_r : PTR_W'((int'(win_s) + 1) % N_REQ);
`ifdef ARB_LOCK_EN
               hold_cnt_nx_s   = keep_s ? hold_cnt_r + HOLD_W'(1) : {HOLD_W{1'b0}};
`endif
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         ptr_r      <= {PTR_W{1'b0}};
         gnt_r      <= {N_REQ{1'b0}};
         wr_stb_r   <= 1'b0;
         owner_r    <= {PTR_W{1'b0}};
         q_r        <= {WIDTH{1'b0}};
         q_valid_r  <= 1'b0;
`ifdef ARB_LOCK_EN
         hold_cnt_r <= {HOLD_W{1'b0}};
`endif
      end else begin
         state_r    <= state_nx_s;
         ptr_r      <= ptr_nx_s;
         gnt_r      <= gnt_nx_s;
         wr_stb_r   <= wr_stb_nx_s;
         owner_r    <= owner_nx_s;
         q_r        <= q_nx_s;
         q_valid_r  <= q_valid_nx_s;
`ifdef ARB_LOCK_EN
         hold_cnt_r <= hold_cnt_nx_s;
`endif
      end
   end

   assign gnt     = gnt_r;
   assign wr_stb  = wr_stb_r;
   assign owner   = owner_r;
   assign q       = q_r;
   assign q_valid = q_valid_r;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scoreboard bench for rr_reg_arbiter: stimulus pushes model predictions, a monitor
// pops and compares one prediction per clock. Honours ARB_LOCK_EN when defined.
module tb_rr_reg_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MH = 4;
`ifdef ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N*W-1:0] wdata;
   logic [N-1:0]  lock;
   logic [N-1:0]  gnt;
   logic          wr_stb;
   logic [1:0]    owner;
   logic [W-1:0]  q;
   logic          q_valid;

   rr_reg_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .wdata   (wdata),
`ifdef ARB_LOCK_EN
      .lock    (lock),
`endif
      .gnt     (gnt),
      .wr_stb  (wr_stb),
      .owner   (owner),
      .q       (q),
      .q_valid (q_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] gnt;
      logic         wr_stb;
      logic [1:0]   owner;
      logic [W-1:0] q;
      logic         q_valid;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pushed = 0;
   int   n_popped = 0;

   // Reference model state: priority pointer, last winner, stored data, lock run length.
   int         m_ptr = 0;
   int         m_owner = 0;
   logic [W-1:0] m_q = '0;
   bit         m_qv = 1'b0;
   bit         m_busy = 1'b0;
   int         m_run = 0;

   function automatic exp_t model_step(input bit rst, input logic [N-1:0] r,
                                       input logic [N*W-1:0] wd, input logic [N-1:0] lk);
      exp_t e;
      int   w;
      int   best;
      e = '0;
      if (rst) begin
         m_ptr = 0; m_owner = 0; m_q = '0; m_qv = 1'b0; m_busy = 1'b0; m_run = 0;
      end else if (r == '0) begin
         m_busy = 1'b0;
         m_run  = 0;
         e.owner = 2'(m_owner); e.q = m_q; e.q_valid = m_qv;
      end else begin
         if (LOCK_EN && m_busy && r[m_owner] && lk[m_owner] && m_run < MH) begin
            w = m_owner;
            m_run++;
         end else begin
            // winner = requester at the smallest rotational distance from the pointer
            best = N; w = 0;
            for (int i = 0; i < N; i++) begin
               if (r[i] && ((i - m_ptr + N) % N) < best) begin
                  best = (i - m_ptr + N) % N;
                  w = i;
               end
            end
            m_run = 1;
            m_ptr = (w + 1) % N;
         end
         m_owner = w; m_q = wd[w*W +: W]; m_qv = 1'b1; m_busy = 1'b1;
         e.gnt = N'(1 << w); e.wr_stb = 1'b1; e.owner = 2'(w); e.q = m_q; e.q_valid = 1'b1;
      end
      return e;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   // Monitor: one prediction is consumed per clock, sampled 1 time unit after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_popped++;
         check("gnt",     int'(gnt),     int'(mon_e.gnt));
         check("wr_stb",  int'(wr_stb),  int'(mon_e.wr_stb));
         check("owner",   int'(owner),   int'(mon_e.owner));
         check("q",       int'(q),       int'(mon_e.q));
         check("q_valid", int'(q_valid), int'(mon_e.q_valid));
      end
   end

   task automatic step(input bit rst, input logic [N-1:0] r,
                       input logic [N*W-1:0] wd, input logic [N-1:0] lk);
      reset = rst; req = r; wdata = wd; lock = lk;
      exp_q.push_back(model_step(rst, r, wd, lk));
      n_pushed++;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0]   r;
      logic [N*W-1:0] wd;
      logic [N-1:0]   lk;
      int             wait_cyc;

      // reset held two cycles with every port requesting
      step(1'b1, 4'hF, 32'h44332211, 4'h0);
      step(1'b1, 4'hF, 32'h44332211, 4'h0);
      // single request on port 2
      step(1'b0, 4'b0100, 32'h00A50000, 4'h0);
      // idle hold, then resume from owner+1
      step(1'b0, 4'h0, 32'hDEADBEEF, 4'h0);
      step(1'b0, 4'h0, 32'hCAFEF00D, 4'h0);
      step(1'b0, 4'hF, 32'h0D0C0B0A, 4'h0);
      // all requesting after reset: strict rotation
      step(1'b1, 4'h0, 32'h0, 4'h0);
      for (int k = 0; k < 8; k++) begin
         wd = {8'(8'h40 + k), 8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
         step(1'b0, 4'hF, wd, 4'h0);
      end
      // reset in the middle of rotation at owner 2, then restart from port 0
      step(1'b1, 4'h0, 32'h0, 4'h0);
      step(1'b0, 4'hF, 32'h11223344, 4'h0);
      step(1'b0, 4'hF, 32'h55667788, 4'h0);
      step(1'b0, 4'hF, 32'h99AABBCC, 4'h0);
      step(1'b1, 4'hF, 32'hDDEEFF00, 4'h0);
      step(1'b0, 4'hF, 32'h12345678, 4'h0);
      // ports 0 and 1 requesting with port 0 locking
      step(1'b1, 4'h0, 32'h0, 4'h0);
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 4'b0011, {16'h0, 8'(8'hB0 + k), 8'(8'hA0 + k)}, 4'b0001);
      end
      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         r  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) r = 4'h0;
         wd = 32'($urandom);
         lk = 4'($urandom_range(0, 15));
         step($urandom_range(0, 49) == 0, r, wd, lk);
      end
      reset = 1'b0; req = 4'h0;

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("drain", n_popped, n_pushed);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
